qsfp_health_scan: RTL and testbench
===================================

Name: qsfp_health_scan

Overview:
Autonomous poller sitting directly downstream of the Marble QSFP readout wrapper, on its readAddress/readData port. It periodically walks the presence byte, temperature, supply voltage and four RX-power words of every QSFP. It publishes a coherent snapshot with sticky threshold alarms to the processor register map, so firmware no longer byte-bangs the wrapper.

Parameters:
QSFP_COUNT, 2, number of QSFP cages scanned (address bits above [7:0] select the cage)
CLOCK_RATE, 100000000, clk frequency in Hz
SCAN_PERIOD_MS, 100, idle time between scans
READ_LATENCY, 1, clk cycles from readAddress change to valid readData (1..4)
PRS_BIT, 0, bit of the presence byte carrying MOD_PRS (low = present)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
readAddress  out  $clog2(QSFP_COUNT)+8  byte address to readout wrapper
readData  in  8  byte returned by readout wrapper
bus_claim  in  1  debug bus owns the wrapper; scan reads are invalid while high
scan_now  in  1  single-cycle request for an immediate scan
alarm_clear  in  1  single-cycle clear of all sticky alarms
temp_hi  in  16  signed temperature limit, 1/256 degC
vcc_lo  in  16  unsigned supply low limit, 100 uV
rx_lo  in  16  unsigned RX-power low limit, 0.1 uW
present  out  QSFP_COUNT  module present, per cage
temperature  out  16*QSFP_COUNT  signed, cage 0 in LSBs
vsupply  out  16*QSFP_COUNT  unsigned
rxpower_min  out  16*QSFP_COUNT  minimum of the four lanes
alarm  out  3*QSFP_COUNT  sticky {rx_low, vcc_low, temp_high} per cage
scan_busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse when the snapshot commits
scan_count  out  16  wrapping count of completed scans

Behaviour:
- Reset: all outputs 0; readAddress 0; interval counter 0; FSM in IDLE; no pending request.
- Byte list per cage (13 bytes), in this order: presence byte; temperature MSB, LSB; vsupply MSB, LSB; rxpower lane0..3 MSB, LSB. Offsets are taken from the shared QSFP offset constants; the cage index goes in readAddress[$clog2(QSFP_COUNT)+7:8].
- FSM: IDLE -> ISSUE -> WAIT -> CAPTURE -> (ISSUE for the next byte | COMMIT) -> IDLE.
  - ISSUE drives the address.
  - WAIT holds for READ_LATENCY-1 cycles.
  - CAPTURE samples readData into shadow registers.
  - Each byte costs READ_LATENCY+1 cycles.
  - readAddress holds its value outside ISSUE/WAIT/CAPTURE.
- Leaving IDLE requires either the interval counter to reach CLOCK_RATE/1000*SCAN_PERIOD_MS-1, or a pending scan_now. The counter restarts at COMMIT.
- scan_now while busy sets a single pending flag; the next scan starts in the cycle after COMMIT. Multiple requests collapse into one.
- bus_claim:
  - In ISSUE or WAIT: the FSM stalls in ISSUE until bus_claim is low, then restarts that byte's latency count.
  - In CAPTURE: the byte is discarded and reissued.
  - A claimed byte is never captured.
- COMMIT (one cycle):
  - Shadow values are copied to the outputs atomically.
  - scan_done is pulsed in the following cycle.
  - scan_count increments and wraps 0xFFFF->0.
  - scan_busy is high from leaving IDLE through COMMIT.
- Absent cage (presence bit = 1):
  - temperature, vsupply and rxpower_min publish 0.
  - No alarms are set for that cage.
  - Its remaining 12 bytes are still read, which keeps timing fixed.
- rxpower_min is an unsigned running minimum over the 4 lanes, computed during capture.
- Alarms, evaluated only at COMMIT and only for present cages:
  - temp_high when temperature > temp_hi (signed compare).
  - vcc_low when vsupply < vcc_lo.
  - rx_low when rxpower_min < rx_lo.
- Alarm bits are sticky until alarm_clear. If alarm_clear and a set event occur in the same COMMIT cycle, set wins.
- Reset asserted mid-scan: immediate return to the reset state; no partial snapshot is ever published.

Decomposition:
- Package qsfp_health_pkg:
  - byte-offset constants (presence, temperature, vsupply, rxpower0);
  - BYTES_PER_CAGE = 13;
  - field-index enum;
  - alarm bit positions.
- One sub-module, qsfp_health_eval: per-cage shadow registers, lane-minimum logic, threshold compare and sticky alarms. It is instantiated QSFP_COUNT times; the parent holds the FSM, address generation and interval timer.

Test Plan:
1. Model returns presence 0x00, temperature 0x1A80, vsupply 0x80E8, lanes 0x0100/0x00F0/0x0200/0x0300 on cage 0; pulse scan_now -> with READ_LATENCY=1, scan_done is high exactly 53 cycles after scan_now; temperature[15:0]=0x1A80, vsupply[15:0]=0x80E8, rxpower_min[15:0]=0x00F0, scan_count=1.
2. Cage 1 presence byte 0x01 with nonzero payload and thresholds all violated -> present=2'b01; cage 1 outputs all 0; alarm[5:3]=0.
3. temp_hi=0x1A00, vcc_lo=0x9000, rx_lo=0x0100 with scenario-1 data -> alarm[2:0]=3'b111. Pulse alarm_clear, then rescan with in-range data -> alarm[2:0]=0. alarm_clear coinciding with COMMIT on violating data -> the bits stay set.
4. Raise bus_claim for 7 cycles mid-scan while the model drives garbage (0xEE) -> no 0xEE appears in any output; scan_done is delayed by at least 7 cycles.
5. SCAN_PERIOD_MS=1, CLOCK_RATE=100000 -> successive scan_done pulses are 100 cycles plus the scan duration apart. Three scan_now pulses during one scan -> exactly one extra scan.
6. Deassert rst_n at byte 9 of a scan, then release -> all outputs 0, scan_count=0; the next scan completes normally.

Source files
------------

// File: rtl/qsfp_health_pkg.sv
// Shared constants and types for the QSFP health scanner.
package qsfp_health_pkg;

  // Byte offsets within one cage's readout window
  localparam logic [7:0] OFS_PRESENCE    = 8'h00;
  localparam logic [7:0] OFS_TEMPERATURE = 8'h16;
  localparam logic [7:0] OFS_VSUPPLY     = 8'h1A;
  localparam logic [7:0] OFS_RXPOWER0    = 8'h22;

  localparam int BYTES_PER_CAGE = 13;

  // Alarm bit positions within a cage's 3-bit alarm field
  localparam int ALM_TEMP_HIGH = 0;
  localparam int ALM_VCC_LOW   = 1;
  localparam int ALM_RX_LOW    = 2;

  // Order in which the bytes of one cage are read
  typedef enum logic [3:0] {
    FLD_PRS,
    FLD_TEMP_HI, FLD_TEMP_LO,
    FLD_VCC_HI,  FLD_VCC_LO,
    FLD_RX0_HI,  FLD_RX0_LO,
    FLD_RX1_HI,  FLD_RX1_LO,
    FLD_RX2_HI,  FLD_RX2_LO,
    FLD_RX3_HI,  FLD_RX3_LO
  } field_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CAPTURE,
    ST_COMMIT
  } state_e;

  // Byte offset of a field; RX lanes are four consecutive big-endian words
  function automatic logic [7:0] field_offset(input field_e f);
    logic [7:0] ofs;
    case (f)
      FLD_PRS:     ofs = OFS_PRESENCE;
      FLD_TEMP_HI: ofs = OFS_TEMPERATURE;
      FLD_TEMP_LO: ofs = OFS_TEMPERATURE + 8'd1;
      FLD_VCC_HI:  ofs = OFS_VSUPPLY;
      FLD_VCC_LO:  ofs = OFS_VSUPPLY + 8'd1;
      default:     ofs = OFS_RXPOWER0 + {4'd0, f} - 8'd5;
    endcase
    return ofs;
  endfunction

endpackage

// File: rtl/qsfp_health_eval.sv
// Per-cage shadow capture, RX lane minimum, threshold compare and sticky alarms.
module qsfp_health_eval
  import qsfp_health_pkg::*;
#(
  parameter int PRS_BIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap_en,
  input  field_e      fld,
  input  logic [7:0]  rd_data,
  input  logic        commit,
  input  logic        alarm_clear,
  input  logic [15:0] temp_hi,
  input  logic [15:0] vcc_lo,
  input  logic [15:0] rx_lo,
  output logic        present,
  output logic [15:0] temperature,
  output logic [15:0] vsupply,
  output logic [15:0] rxpower_min,
  output logic [2:0]  alarm
);

  logic        prs_s_q, prs_s_d;
  logic [7:0]  msb_s_q, msb_s_d;
  logic [15:0] temp_s_q, temp_s_d;
  logic [15:0] vcc_s_q, vcc_s_d;
  logic [15:0] rxmin_s_q, rxmin_s_d;
  logic        present_q, present_d;
  logic [15:0] temp_q, temp_d;
  logic [15:0] vcc_q, vcc_d;
  logic [15:0] rxmin_q, rxmin_d;
  logic [2:0]  alarm_q, alarm_d;
  logic [15:0] word_s;
  logic        mod_present;
  logic [2:0]  set_ev;

  // Shadow and published registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prs_s_q   <= 1'b1;
      msb_s_q   <= '0;
      temp_s_q  <= '0;
      vcc_s_q   <= '0;
      rxmin_s_q <= '0;
      present_q <= 1'b0;
      temp_q    <= '0;
      vcc_q     <= '0;
      rxmin_q   <= '0;
      alarm_q   <= '0;
    end else begin
      prs_s_q   <= prs_s_d;
      msb_s_q   <= msb_s_d;
      temp_s_q  <= temp_s_d;
      vcc_s_q   <= vcc_s_d;
      rxmin_s_q <= rxmin_s_d;
      present_q <= present_d;
      temp_q    <= temp_d;
      vcc_q     <= vcc_d;
      rxmin_q   <= rxmin_d;
      alarm_q   <= alarm_d;
    end
  end

  // Byte capture: MSBs park in msb_s, the LSB completes the word
  always_comb begin
    word_s    = {msb_s_q, rd_data};
    prs_s_d   = prs_s_q;
    msb_s_d   = msb_s_q;
    temp_s_d  = temp_s_q;
    vcc_s_d   = vcc_s_q;
    rxmin_s_d = rxmin_s_q;
    if (cap_en) begin
      case (fld)
        FLD_PRS:     prs_s_d = rd_data[PRS_BIT];
        FLD_TEMP_LO: temp_s_d = word_s;
        FLD_VCC_LO:  vcc_s_d = word_s;
        FLD_RX0_LO:  rxmin_s_d = word_s;
        FLD_RX1_LO, FLD_RX2_LO, FLD_RX3_LO: begin
          if (word_s < rxmin_s_q) rxmin_s_d = word_s;
        end
        default:     msb_s_d = rd_data;
      endcase
    end
  end

  // Commit: publish the snapshot and fold new alarm events in; set beats clear
  always_comb begin
    mod_present = ~prs_s_q;
    set_ev = '0;
    set_ev[ALM_TEMP_HIGH] = mod_present && ($signed(temp_s_q) > $signed(temp_hi));
    set_ev[ALM_VCC_LOW]   = mod_present && (vcc_s_q < vcc_lo);
    set_ev[ALM_RX_LOW]    = mod_present && (rxmin_s_q < rx_lo);
    present_d = present_q;
    temp_d    = temp_q;
    vcc_d     = vcc_q;
    rxmin_d   = rxmin_q;
    if (commit) begin
      present_d = mod_present;
      temp_d    = mod_present ? temp_s_q  : '0;
      vcc_d     = mod_present ? vcc_s_q   : '0;
      rxmin_d   = mod_present ? rxmin_s_q : '0;
    end
    alarm_d = (alarm_clear ? 3'b000 : alarm_q) | (commit ? set_ev : 3'b000);
  end

  // Output drive
  always_comb begin
    present     = present_q;
    temperature = temp_q;
    vsupply     = vcc_q;
    rxpower_min = rxmin_q;
    alarm       = alarm_q;
  end

endmodule

// File: rtl/qsfp_health_scan.sv
// Periodic QSFP health poller on the readout wrapper's byte port.
//
// state   | meaning
// IDLE    | waiting for interval timeout or a scan request
// ISSUE   | address driven; held here while the debug bus owns the wrapper
// WAIT    | remaining read latency beyond the first cycle
// CAPTURE | readData valid, sampled into the cage shadow registers
// COMMIT  | shadow copied to outputs, alarms evaluated, timer restarted
module qsfp_health_scan
  import qsfp_health_pkg::*;
#(
  parameter int QSFP_COUNT     = 2,
  parameter int CLOCK_RATE     = 100000000,
  parameter int SCAN_PERIOD_MS = 100,
  parameter int READ_LATENCY   = 1,
  parameter int PRS_BIT        = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [$clog2(QSFP_COUNT)+7:0] readAddress,
  input  logic [7:0]                    readData,
  input  logic                          bus_claim,
  input  logic                          scan_now,
  input  logic                          alarm_clear,
  input  logic [15:0]                   temp_hi,
  input  logic [15:0]                   vcc_lo,
  input  logic [15:0]                   rx_lo,
  output logic [QSFP_COUNT-1:0]         present,
  output logic [16*QSFP_COUNT-1:0]      temperature,
  output logic [16*QSFP_COUNT-1:0]      vsupply,
  output logic [16*QSFP_COUNT-1:0]      rxpower_min,
  output logic [3*QSFP_COUNT-1:0]       alarm,
  output logic                          scan_busy,
  output logic                          scan_done,
  output logic [15:0]                   scan_count
);

  localparam int             CIW        = $clog2(QSFP_COUNT);
  localparam logic [31:0]    PERIOD_TC  = 32'(CLOCK_RATE / 1000 * SCAN_PERIOD_MS - 1);
  localparam logic [2:0]     WAIT_LOAD  = 3'(READ_LATENCY - 2);
  localparam logic [CIW-1:0] LAST_CAGE  = CIW'(QSFP_COUNT - 1);
  localparam field_e         LAST_FIELD = field_e'(BYTES_PER_CAGE - 1);

  state_e         state_q, state_d;
  field_e         byte_q, byte_d;
  logic [CIW-1:0] cage_q, cage_d;
  logic [CIW+7:0] addr_q, addr_d;
  logic [2:0]     wait_q, wait_d;
  logic [31:0]    ivl_q, ivl_d;
  logic           pend_q, pend_d;
  logic           done_q, done_d;
  logic [15:0]    count_q, count_d;
  logic           last_byte, cap_valid, commit;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      byte_q  <= FLD_PRS;
      cage_q  <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
      ivl_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      cage_q  <= cage_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
      ivl_q   <= ivl_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // Next-state: a claimed bus restarts the current byte from ISSUE
  always_comb begin
    last_byte = (byte_q == LAST_FIELD) && (cage_q == LAST_CAGE);
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (ivl_q == PERIOD_TC || pend_q || scan_now) state_d = ST_ISSUE;
      ST_ISSUE:   if (!bus_claim) state_d = (READ_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
      ST_WAIT: begin
        if (bus_claim)          state_d = ST_ISSUE;
        else if (wait_q == '0)  state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (bus_claim)          state_d = ST_ISSUE;
        else if (last_byte)     state_d = ST_COMMIT;
        else                    state_d = ST_ISSUE;
      end
      ST_COMMIT:  state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Byte/cage walk, address, latency down-counter, interval timer, request flag
  always_comb begin
    byte_d  = byte_q;
    cage_d  = cage_q;
    addr_d  = addr_q;
    wait_d  = wait_q;
    ivl_d   = ivl_q;
    pend_d  = pend_q;
    count_d = count_q;
    done_d  = (state_q == ST_COMMIT);

    if (state_q == ST_IDLE && state_d == ST_ISSUE) begin
      pend_d = 1'b0;
      byte_d = FLD_PRS;
      cage_d = '0;
    end else if (scan_now) begin
      pend_d = 1'b1;
    end

    if (state_q == ST_CAPTURE && !bus_claim && !last_byte) begin
      if (byte_q == LAST_FIELD) begin
        byte_d = FLD_PRS;
        cage_d = cage_q + CIW'(1);
      end else begin
        byte_d = field_e'(byte_q + 4'd1);
      end
    end

    if (state_d == ST_ISSUE) addr_d = {cage_d, field_offset(byte_d)};

    if (state_q == ST_ISSUE && state_d == ST_WAIT) wait_d = WAIT_LOAD;
    else if (state_q == ST_WAIT)                   wait_d = wait_q - 3'd1;

    if (state_q == ST_COMMIT) begin
      ivl_d   = '0;
      count_d = count_q + 16'd1;
    end else if (state_q == ST_IDLE && ivl_q != PERIOD_TC) begin
      ivl_d = ivl_q + 32'd1;
    end
  end

  // Outputs decoded from state and registers
  always_comb begin
    scan_busy   = (state_q != ST_IDLE);
    scan_done   = done_q;
    scan_count  = count_q;
    readAddress = addr_q;
    cap_valid   = (state_q == ST_CAPTURE) && !bus_claim;
    commit      = (state_q == ST_COMMIT);
  end

  for (genvar c = 0; c < QSFP_COUNT; c++) begin : g_cage
    qsfp_health_eval #(.PRS_BIT(PRS_BIT)) u_eval (
      .clk         (clk),
      .rst_n       (rst_n),
      .cap_en      (cap_valid && (cage_q == CIW'(c))),
      .fld         (byte_q),
      .rd_data     (readData),
      .commit      (commit),
      .alarm_clear (alarm_clear),
      .temp_hi     (temp_hi),
      .vcc_lo      (vcc_lo),
      .rx_lo       (rx_lo),
      .present     (present[c]),
      .temperature (temperature[16*c +: 16]),
      .vsupply     (vsupply[16*c +: 16]),
      .rxpower_min (rxpower_min[16*c +: 16]),
      .alarm       (alarm[3*c +: 3])
    );
  end

endmodule

// File: tb/tb_qsfp_health_scan.sv
// Scoreboard bench for qsfp_health_scan with a 1-cycle-latency wrapper model.
module tb_qsfp_health_scan;
  import qsfp_health_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  readAddress;
  logic [7:0]  readData;
  logic        bus_claim, scan_now, alarm_clear;
  logic [15:0] temp_hi, vcc_lo, rx_lo;
  logic [1:0]  present;
  logic [31:0] temperature, vsupply, rxpower_min;
  logic [5:0]  alarm;
  logic        scan_busy, scan_done;
  logic [15:0] scan_count;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  present;
    logic [31:0] temp;
    logic [31:0] vs;
    logic [31:0] rx;
    logic [5:0]  alarm;
    logic [15:0] count;
  } exp_t;
  exp_t exp_q[$];

  qsfp_health_scan #(
    .QSFP_COUNT(2), .CLOCK_RATE(100000), .SCAN_PERIOD_MS(1),
    .READ_LATENCY(1), .PRS_BIT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .readAddress(readAddress), .readData(readData),
    .bus_claim(bus_claim), .scan_now(scan_now), .alarm_clear(alarm_clear),
    .temp_hi(temp_hi), .vcc_lo(vcc_lo), .rx_lo(rx_lo),
    .present(present), .temperature(temperature), .vsupply(vsupply),
    .rxpower_min(rxpower_min), .alarm(alarm), .scan_busy(scan_busy),
    .scan_done(scan_done), .scan_count(scan_count)
  );

  always #5 clk = ~clk;

  // Wrapper model: one cycle latency, garbage while the debug bus holds it
  logic [7:0] mem [0:511];
  logic [7:0] rd_q;
  always @(posedge clk) rd_q <= bus_claim ? 8'hEE : mem[readAddress];
  assign readData = bus_claim ? 8'hEE : rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic load_cage(input int c, input logic [7:0] prs, input logic [15:0] t,
                           input logic [15:0] v, input logic [15:0] l0, input logic [15:0] l1,
                           input logic [15:0] l2, input logic [15:0] l3);
    logic [15:0] ln [4];
    int b;
    b = c * 256;
    ln[0] = l0; ln[1] = l1; ln[2] = l2; ln[3] = l3;
    mem[b + int'(OFS_PRESENCE)]        = prs;
    mem[b + int'(OFS_TEMPERATURE)]     = t[15:8];
    mem[b + int'(OFS_TEMPERATURE) + 1] = t[7:0];
    mem[b + int'(OFS_VSUPPLY)]         = v[15:8];
    mem[b + int'(OFS_VSUPPLY) + 1]     = v[7:0];
    for (int k = 0; k < 4; k++) begin
      mem[b + int'(OFS_RXPOWER0) + 2*k]     = ln[k][15:8];
      mem[b + int'(OFS_RXPOWER0) + 2*k + 1] = ln[k][7:0];
    end
  endtask

  task automatic push_exp(input logic [1:0] p, input logic [31:0] t, input logic [31:0] v,
                          input logic [31:0] r, input logic [5:0] a, input logic [15:0] cnt);
    exp_t e;
    e.present = p; e.temp = t; e.vs = v; e.rx = r; e.alarm = a; e.count = cnt;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_present"}, 32'(present), 0);
    chk({tag, "_temp"}, temperature, 0);
    chk({tag, "_vsupply"}, vsupply, 0);
    chk({tag, "_rxmin"}, rxpower_min, 0);
    chk({tag, "_alarm"}, 32'(alarm), 0);
    chk({tag, "_busy"}, 32'(scan_busy), 0);
    chk({tag, "_done"}, 32'(scan_done), 0);
    chk({tag, "_count"}, 32'(scan_count), 0);
    chk({tag, "_addr"}, 32'(readAddress), 0);
  endtask

  // Monitor: every scan_done pops one expected snapshot
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (rst_n === 1'b1 && scan_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got scan_done with count %h want none", scan_count);
        end else begin
          e = exp_q.pop_front();
          chk("snap_present", 32'(present), 32'(e.present));
          chk("snap_temp", temperature, e.temp);
          chk("snap_vsupply", vsupply, e.vs);
          chk("snap_rxmin", rxpower_min, e.rx);
          chk("snap_alarm", 32'(alarm), 32'(e.alarm));
          chk("snap_count", 32'(scan_count), 32'(e.count));
        end
      end
    end
  end

  // n = edges from the one sampling scan_now (or from call time) to scan_done rising
  task automatic run_scan(input bit kick, input int clr_n, input int clm_n, input int clm_len,
                          input bit triple, output int n);
    n = 0;
    if (kick) begin
      scan_now = 1'b1;
      @(posedge clk); #1;
      scan_now = 1'b0;
    end
    forever begin
      alarm_clear = (n == clr_n);
      bus_claim   = (n >= clm_n) && (n < clm_n + clm_len);
      scan_now    = triple && (n == 10 || n == 20 || n == 30);
      @(posedge clk); #1;
      n++;
      if (scan_done) break;
      if (n > 400) begin
        total++; bad++;
        $display("FAIL scan_timeout: got no scan_done after %0d cycles want one", n);
        break;
      end
    end
    alarm_clear = 1'b0;
    bus_claim   = 1'b0;
    scan_now    = 1'b0;
  endtask

  initial begin
    int n;
    int extra;
    rst_n = 1'b0; scan_now = 1'b0; alarm_clear = 1'b0; bus_claim = 1'b0;
    temp_hi = 16'h7FFF; vcc_lo = 16'h0000; rx_lo = 16'h0000;
    for (int i = 0; i < 512; i++) mem[i] = 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Scan 1: both cages present, loose thresholds
    load_cage(0, 8'h00, 16'h1A80, 16'h80E8, 16'h0100, 16'h00F0, 16'h0200, 16'h0300);
    load_cage(1, 8'hFE, 16'hF380, 16'hA000, 16'h0500, 16'h0600, 16'h0400, 16'h0450);
    push_exp(2'b11, {16'hF380, 16'h1A80}, {16'hA000, 16'h80E8}, {16'h0400, 16'h00F0}, 6'b000000, 16'd1);
    run_scan(1'b1, -1, 1000, 0, 1'b0, n);
    chk("latency_scan1", n, 53);

    // Scan 2: tight thresholds, cage 1 absent with violating payload
    temp_hi = 16'h1A00; vcc_lo = 16'h9000; rx_lo = 16'h0100;
    load_cage(1, 8'h01, 16'h7000, 16'h0100, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    push_exp(2'b01, {16'h0000, 16'h1A80}, {16'h0000, 16'h80E8}, {16'h0000, 16'h00F0}, 6'b000111, 16'd2);
    run_scan(1'b1, -1, 1000, 0, 1'b0, n);
    alarm_clear = 1'b1;
    @(posedge clk); #1;
    alarm_clear = 1'b0;
    chk("alarm_after_clear", 32'(alarm), 0);

    // Scan 3: values exactly on the limits raise nothing
    load_cage(0, 8'h00, 16'h1900, 16'h9100, 16'h0300, 16'h0100, 16'h0200, 16'h0250);
    load_cage(1, 8'h00, 16'h1A00, 16'h9000, 16'h0F00, 16'h0E00, 16'h0D00, 16'h0C00);
    push_exp(2'b11, {16'h1A00, 16'h1900}, {16'h9000, 16'h9100}, {16'h0C00, 16'h0100}, 6'b000000, 16'd3);
    run_scan(1'b1, -1, 1000, 0, 1'b0, n);

    // Scan 4: clear lands in the COMMIT cycle; set must win. Cage 1 negative temp.
    load_cage(0, 8'h00, 16'h1A80, 16'h80E8, 16'h0100, 16'h00F0, 16'h0200, 16'h0300);
    load_cage(1, 8'hFE, 16'hF380, 16'hA000, 16'h0500, 16'h0600, 16'h0400, 16'h0450);
    push_exp(2'b11, {16'hF380, 16'h1A80}, {16'hA000, 16'h80E8}, {16'h0400, 16'h00F0}, 6'b000111, 16'd4);
    run_scan(1'b1, 52, 1000, 0, 1'b0, n);
    chk("latency_scan4", n, 53);

    // Scan 5: debug bus claims the wrapper for 7 cycles mid-scan
    push_exp(2'b11, {16'hF380, 16'h1A80}, {16'hA000, 16'h80E8}, {16'h0400, 16'h00F0}, 6'b000111, 16'd5);
    run_scan(1'b1, -1, 20, 7, 1'b0, n);
    chk("claim_delay_ge_60", 32'(n >= 60), 1);

    // Scan 6: interval timer alone, 100 idle cycles plus 53-cycle scan
    push_exp(2'b11, {16'hF380, 16'h1A80}, {16'hA000, 16'h80E8}, {16'h0400, 16'h00F0}, 6'b000111, 16'd6);
    run_scan(1'b0, -1, 1000, 0, 1'b0, n);
    chk("auto_period", n, 153);

    // Scans 7/8: three requests during a scan collapse into one follow-up
    push_exp(2'b11, {16'hF380, 16'h1A80}, {16'hA000, 16'h80E8}, {16'h0400, 16'h00F0}, 6'b000111, 16'd7);
    push_exp(2'b11, {16'hF380, 16'h1A80}, {16'hA000, 16'h80E8}, {16'h0400, 16'h00F0}, 6'b000111, 16'd8);
    run_scan(1'b1, -1, 1000, 0, 1'b1, n);
    chk("latency_scan7", n, 53);
    run_scan(1'b0, -1, 1000, 0, 1'b0, n);
    chk("pending_followup", n, 54);
    extra = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (scan_done) extra++;
    end
    chk("no_extra_scan", extra, 0);

    // Reset in the middle of a scan, then a clean scan
    scan_now = 1'b1;
    @(posedge clk); #1;
    scan_now = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("busy_before_rst", 32'(scan_busy), 1);
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("post_rst");
    load_cage(1, 8'h01, 16'h7000, 16'h0100, 16'h0010, 16'h0020, 16'h0030, 16'h0040);
    push_exp(2'b01, {16'h0000, 16'h1A80}, {16'h0000, 16'h80E8}, {16'h0000, 16'h00F0}, 6'b000111, 16'd1);
    run_scan(1'b1, -1, 1000, 0, 1'b0, n);
    chk("latency_after_rst", n, 53);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
